// File: rtl/circuito_jogo_seq.sv
// Memory game top level: the player reproduces a stored sequence of plays,
// with a per-play time limit and a selectable round length.
module circuito_jogo_seq #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 5000,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [WIDTH-1:0]  chaves,
    input  logic [ADDR_W-1:0] limite,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_data,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic              pronto,
    output logic [WIDTH-1:0]  leds,
    output logic              db_igual,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [WIDTH-1:0]  db_memoria,
    output logic [WIDTH-1:0]  db_jogada,
    output logic [3:0]        db_estado,
    output logic              db_tem_jogada
);

    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARACAO  = 4'h4,
        PROXIMO     = 4'h5,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hC,
        FIM_ERRO    = 4'hE
    } estado_t;

    estado_t estado, estado_prox;

    logic [WIDTH-1:0]  s1, s2, s3;
    logic [WIDTH-1:0]  jogada;
    logic [WIDTH-1:0]  memoria;
    logic [ADDR_W-1:0] contagem;
    logic [ADDR_W-1:0] limite_reg;
    logic [TO_W-1:0]   to_cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic tem_jogada;
    logic igual;
    logic fim_contagem;
    logic to_expirou;
    logic clr_dp;
    logic ld_jogada;
    logic inc_contagem;
    logic inc_to;
    logic mem_wr_ok;

    // Sequence memory: contents survive reset, writes only between rounds
    always_ff @(posedge clock) begin
        if (mem_we && mem_wr_ok) begin
            mem[mem_addr] <= mem_data;
        end
    end

    assign memoria      = mem[contagem];
    assign igual        = (jogada == memoria);
    assign fim_contagem = (contagem == limite_reg);
    assign tem_jogada   = (s2 != '0) && (s3 == '0);
    assign to_expirou   = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            jogada     <= '0;
            contagem   <= '0;
            limite_reg <= '0;
            to_cnt     <= '0;
        end else begin
            s1 <= chaves;
            s2 <= s1;
            s3 <= s2;
            if (clr_dp) begin
                jogada     <= '0;
                contagem   <= '0;
                to_cnt     <= '0;
                limite_reg <= limite;
            end else begin
                if (ld_jogada) begin
                    jogada <= s2;
                end
                if (inc_contagem) begin
                    contagem <= contagem + ADDR_W'(1);
                    to_cnt   <= '0;
                end else if (inc_to && (to_cnt != '1)) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox  = estado;
        clr_dp       = 1'b0;
        ld_jogada    = 1'b0;
        inc_contagem = 1'b0;
        inc_to       = 1'b0;
        mem_wr_ok    = 1'b0;
        case (estado)
            INICIAL: begin
                mem_wr_ok = 1'b1;
                if (iniciar) estado_prox = PREPARACAO;
            end
            PREPARACAO: begin
                clr_dp      = 1'b1;
                estado_prox = ESPERA;
            end
            ESPERA: begin
                inc_to = 1'b1;
                // A play seen in the last allowed cycle still counts
                if (tem_jogada)      estado_prox = REGISTRA;
                else if (to_expirou) estado_prox = FIM_TIMEOUT;
            end
            REGISTRA: begin
                ld_jogada   = 1'b1;
                estado_prox = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual)            estado_prox = FIM_ERRO;
                else if (fim_contagem) estado_prox = FIM_ACERTO;
                else                   estado_prox = PROXIMO;
            end
            PROXIMO: begin
                inc_contagem = 1'b1;
                estado_prox  = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                mem_wr_ok = 1'b1;
                if (iniciar) estado_prox = PREPARACAO;
            end
            default: begin
                estado_prox = INICIAL;
            end
        endcase
    end

    assign acertou       = (estado == FIM_ACERTO);
    assign errou         = (estado == FIM_ERRO);
    assign timeout       = (estado == FIM_TIMEOUT);
    assign pronto        = acertou || errou || timeout;
    assign leds          = jogada;
    assign db_jogada     = jogada;
    assign db_igual      = igual;
    assign db_contagem   = contagem;
    assign db_memoria    = memoria;
    assign db_estado     = estado;
    assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_circuito_jogo_seq.sv
// Directed bench for circuito_jogo_seq: table of rounds plus hand-written
// timeout, play-detect, write-protect and asynchronous-reset sequences.
module tb_circuito_jogo_seq;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic [3:0] limite;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [3:0] mem_data;
    logic       acertou, errou, timeout, pronto;
    logic [3:0] leds;
    logic       db_igual;
    logic [3:0] db_contagem;
    logic [3:0] db_memoria;
    logic [3:0] db_jogada;
    logic [3:0] db_estado;
    logic       db_tem_jogada;

    int checks = 0;
    int errors = 0;

    circuito_jogo_seq #(.WIDTH(4), .DEPTH(16), .TIMEOUT(20)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .limite(limite), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .acertou(acertou), .errou(errou), .timeout(timeout), .pronto(pronto),
        .leds(leds), .db_igual(db_igual), .db_contagem(db_contagem),
        .db_memoria(db_memoria), .db_jogada(db_jogada), .db_estado(db_estado),
        .db_tem_jogada(db_tem_jogada)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // start, limite, play, expected estado/contagem/leds/memoria,
    // flags {acertou, errou, timeout, pronto}, igual
    typedef struct {
        logic       start;
        logic [3:0] lim;
        logic [3:0] play;
        logic [3:0] est;
        logic [3:0] cont;
        logic [3:0] leds;
        logic [3:0] mem;
        logic [3:0] flags;
        logic       igual;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        mem_addr = a;
        mem_data = d;
        mem_we   = 1'b1;
        tick();
        mem_we   = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] lim);
        limite  = lim;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
    endtask

    task automatic play(input logic [3:0] v);
        chaves = v;
        repeat (4) tick();
        chaves = 4'd0;
        repeat (4) tick();
    endtask

    task automatic wait_state(input string name, input logic [3:0] st, input int max_cycles);
        int n;
        n = 0;
        while (db_estado !== st && n < max_cycles) begin
            tick();
            n++;
        end
        chk(name, db_estado, st);
    endtask

    task automatic run_table(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (tbl[i].start) do_start(tbl[i].lim);
            play(tbl[i].play);
            chk($sformatf("v%0d_estado", i), db_estado, tbl[i].est);
            chk($sformatf("v%0d_contagem", i), db_contagem, tbl[i].cont);
            chk($sformatf("v%0d_leds", i), leds, tbl[i].leds);
            chk($sformatf("v%0d_jogada", i), db_jogada, tbl[i].leds);
            chk($sformatf("v%0d_memoria", i), db_memoria, tbl[i].mem);
            chk($sformatf("v%0d_flags", i), {acertou, errou, timeout, pronto}, tbl[i].flags);
            chk($sformatf("v%0d_igual", i), db_igual, tbl[i].igual);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        // Round with limite=3 over 1,2,4,8
        tbl[0]  = '{1'b1, 4'd3, 4'd1, 4'h2, 4'd1, 4'd1, 4'd2, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'd3, 4'd2, 4'h2, 4'd2, 4'd2, 4'd4, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 4'd3, 4'd4, 4'h2, 4'd3, 4'd4, 4'd8, 4'b0000, 1'b0};
        tbl[3]  = '{1'b0, 4'd3, 4'd8, 4'hA, 4'd3, 4'd8, 4'd8, 4'b1001, 1'b1};
        // Wrong second play
        tbl[4]  = '{1'b1, 4'd3, 4'd1, 4'h2, 4'd1, 4'd1, 4'd2, 4'b0000, 1'b0};
        tbl[5]  = '{1'b0, 4'd3, 4'd4, 4'hE, 4'd1, 4'd4, 4'd2, 4'b0101, 1'b0};
        // limite=5 over 1,2,4,8,3,6 (mem[5] must not have become 7)
        tbl[6]  = '{1'b1, 4'd5, 4'd1, 4'h2, 4'd1, 4'd1, 4'd2, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 4'd5, 4'd2, 4'h2, 4'd2, 4'd2, 4'd4, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 4'd5, 4'd4, 4'h2, 4'd3, 4'd4, 4'd8, 4'b0000, 1'b0};
        tbl[9]  = '{1'b0, 4'd5, 4'd8, 4'h2, 4'd4, 4'd8, 4'd3, 4'b0000, 1'b0};
        tbl[10] = '{1'b0, 4'd5, 4'd3, 4'h2, 4'd5, 4'd3, 4'd6, 4'b0000, 1'b0};
        tbl[11] = '{1'b0, 4'd5, 4'd6, 4'hA, 4'd5, 4'd6, 4'd6, 4'b1001, 1'b1};
        // Single-entry round
        tbl[12] = '{1'b1, 4'd0, 4'd9, 4'hA, 4'd0, 4'd9, 4'd9, 4'b1001, 1'b1};

        reset    = 1'b0;
        iniciar  = 1'b0;
        chaves   = 4'd0;
        limite   = 4'd0;
        mem_we   = 1'b0;
        mem_addr = 4'd0;
        mem_data = 4'd0;
        tick();
        tick();
        chk("rst_estado", db_estado, 4'h0);
        chk("rst_contagem", db_contagem, 4'd0);
        chk("rst_flags", {acertou, errou, timeout, pronto}, 4'b0000);
        chk("rst_leds", leds, 4'd0);
        chk("rst_tem_jogada", db_tem_jogada, 1'b0);
        reset = 1'b1;
        tick();

        wr(4'd0, 4'd1);
        wr(4'd1, 4'd2);
        wr(4'd2, 4'd4);
        wr(4'd3, 4'd8);
        wr(4'd4, 4'd3);
        wr(4'd5, 4'd6);
        chk("ini_memoria", db_memoria, 4'd1);

        run_table(0, 5);

        // No play: timeout after 20 cycles in espera
        do_start(4'd3);
        chk("to_entry_flags", {acertou, errou, timeout, pronto}, 4'b0000);
        repeat (19) tick();
        chk("to_c19_estado", db_estado, 4'h2);
        chk("to_c19_timeout", timeout, 1'b0);
        tick();
        chk("to_estado", db_estado, 4'hC);
        chk("to_flags", {acertou, errou, timeout, pronto}, 4'b0011);
        chk("to_contagem", db_contagem, 4'd0);

        // Play detected on the last allowed cycle wins over the timeout
        do_start(4'd3);
        repeat (17) tick();
        chaves = 4'd1;
        tick();
        tick();
        chk("late_pulse", db_tem_jogada, 1'b1);
        chk("late_estado_espera", db_estado, 4'h2);
        tick();
        chk("late_registra", db_estado, 4'h3);
        chk("late_no_timeout", timeout, 1'b0);
        repeat (3) tick();
        chk("late_estado", db_estado, 4'h2);
        chk("late_contagem", db_contagem, 4'd1);
        chk("late_leds", leds, 4'd1);
        chaves = 4'd0;
        // iniciar mid-round is ignored
        iniciar = 1'b1;
        tick();
        tick();
        iniciar = 1'b0;
        chk("ign_ini_estado", db_estado, 4'h2);
        chk("ign_ini_contagem", db_contagem, 4'd1);
        wait_state("late_wait_to", 4'hC, 40);

        // Held switches give one pulse; write in espera is ignored
        wr(4'd0, 4'd2);
        do_start(4'd3);
        wr(4'd5, 4'd7);
        pulses = 0;
        chaves = 4'd2;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (db_tem_jogada === 1'b1) pulses++;
        end
        chaves = 4'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (db_tem_jogada === 1'b1) pulses++;
        end
        chk("hold_pulses", pulses, 1);
        chk("hold_contagem", db_contagem, 4'd1);
        chk("hold_leds", leds, 4'd2);
        chk("hold_estado", db_estado, 4'hC);
        chaves = 4'd0;
        repeat (4) tick();

        wr(4'd0, 4'd1);
        run_table(6, 11);

        wr(4'd0, 4'd9);
        run_table(12, 12);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("restart_prep", db_estado, 4'h1);
        chk("restart_prep_flags", {acertou, errou, timeout, pronto}, 4'b0000);
        tick();
        chk("restart_espera", db_estado, 4'h2);
        chk("restart_flags", {acertou, errou, timeout, pronto}, 4'b0000);
        chk("restart_contagem", db_contagem, 4'd0);
        chk("restart_leds", leds, 4'd0);
        wait_state("restart_wait_to", 4'hC, 40);

        // Asynchronous reset in the middle of a round
        wr(4'd0, 4'd1);
        run_table(0, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_estado", db_estado, 4'h0);
        chk("arst_contagem", db_contagem, 4'd0);
        chk("arst_flags", {acertou, errou, timeout, pronto}, 4'b0000);
        chk("arst_leds", leds, 4'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("arst_memoria", db_memoria, 4'd1);
        chk("arst_idle", db_estado, 4'h0);
        run_table(0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/circuito_jogo_seq.md
Name: circuito_jogo_seq

Overview:
- Parametrised successor of the single-sequence memory game top level.
- Instantiates an internal datapath (writable sequence memory, address counter, play register, comparator, timeout counter) and a control FSM.
- The player reproduces a stored sequence of WIDTH-bit plays whose length is selectable at start.
- Each play has a time limit; a stalled player ends the round in a dedicated timeout outcome.
- Debug outputs are raw binary; the board wrapper handles 7-segment decoding.

Parameters:
- WIDTH, 4, bits per play (chaves, memory word).
- DEPTH, 16, number of sequence memory words; ADDR_W = clog2(DEPTH).
- TIMEOUT, 5000, max cycles waiting for a play; 0 disables timeout.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately.
- iniciar  in  1  start/restart request; level-sampled by the FSM.
- chaves  in  WIDTH  player switches; one play = transition from all-zero to nonzero.
- limite  in  ADDR_W  last index to play; round length = limite+1; latched in preparacao.
- mem_we  in  1  sequence memory write enable.
- mem_addr  in  ADDR_W  write address.
- mem_data  in  WIDTH  write data.
- acertou  out  1  round completed correctly.
- errou  out  1  wrong play.
- timeout  out  1  play window expired.
- pronto  out  1  round finished (any outcome).
- leds  out  WIDTH  registered play.
- db_igual  out  1  comparator output (play register == memory[contagem]).
- db_contagem  out  ADDR_W  current address.
- db_memoria  out  WIDTH  memory[contagem].
- db_jogada  out  WIDTH  registered play (same as leds).
- db_estado  out  4  FSM state code.
- db_tem_jogada  out  1  one-cycle play-detect pulse.

Behaviour:
- Reset (reset=0): FSM=inicial, contagem=0, play register=0, timeout counter=0, latched limite=0, sync flops=0. All flag outputs 0.
- Memory contents are not reset and are retained across reset.
- Input conditioning: chaves passes through a 2-flop synchroniser (s1, s2) plus a history flop s3.
  - db_tem_jogada = (s2!=0) && (s3==0).
  - Consequence: FSM leaves espera on the 3rd rising edge after chaves goes nonzero.
  - Holding chaves nonzero produces exactly one pulse. Changing between two nonzero values produces none.
- Memory:
  - Synchronous write when mem_we=1, honoured only in inicial, fim_acerto, fim_erro, fim_timeout; ignored in all other states.
  - Asynchronous read at contagem.
- FSM states (db_estado code):
  - inicial 0: iniciar=1 -> preparacao.
  - preparacao 1: clear contagem, play register and timeout counter; latch limite. Always -> espera.
  - espera 2: timeout counter increments each cycle.
    - db_tem_jogada=1 -> registra. A play takes priority over timeout in the same cycle.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> fim_timeout.
  - registra 3: play register <= s2. -> comparacao.
  - comparacao 4:
    - !igual -> fim_erro.
    - igual && contagem==latched limite -> fim_acerto.
    - Else -> proximo.
  - proximo 5: contagem+1, timeout counter cleared. -> espera.
  - fim_acerto 0xA, fim_erro 0xE, fim_timeout 0xC: pronto=1 plus the matching flag.
    - Outputs, contagem and play register are held.
    - iniciar=1 -> preparacao, which clears the flags the next cycle.
  - Any unused code -> inicial.
- Flags acertou, errou, timeout and pronto are Moore outputs decoded from state; they are mutually exclusive apart from pronto.
- Widths: contagem never exceeds latched limite.
  - limite=DEPTH-1 plays the full memory; limite=0 plays one entry.
  - Timeout counter width is clog2(TIMEOUT+1), saturating, never wraps.
- iniciar during a round (states 1–5) is ignored.
- Async reset at any time returns to inicial within the same cycle, including mid-write and mid-round.

Test Plan:
- WIDTH=4, DEPTH=16, TIMEOUT=20: write mem[0..3]=1,2,4,8; limite=3; iniciar; play 1,2,4,8, each chaves pulse 4 cycles high and 4 low -> acertou=1, pronto=1, db_estado=0xA, db_contagem=3, leds=8.
- Same memory, play 1,4 -> after the 2nd play errou=1, pronto=1, db_estado=0xE, db_contagem=1, leds=4, acertou=0.
- Iniciar, then no play for 20 cycles in espera -> timeout=1, db_estado=0xC, db_contagem=0. Repeat, making a play on cycle 19 -> registra taken, no timeout.
- Hold chaves=2 for 30 cycles, then change 2->3 -> exactly one db_tem_jogada pulse, one contagem advance. Write mem[5]=7 with mem_we while in espera -> mem[5] unchanged (check via a later round with limite reaching 5).
- limite=0, mem[0]=9, play 9 -> fim_acerto. Then iniciar -> flags clear one cycle after preparacao and db_estado=2.
- Assert reset=0 asynchronously mid-round (db_estado=2, contagem=2) -> all flags 0, db_estado=0, db_contagem=0 before the next clock edge; memory contents preserved.
